scr1_ialu_issue: RTL

- EXU-side issue stage directly upstream of the IALU.
- Accepts decoded ALU/MUL/DIV requests from decode via a valid/ready handshake, registers the operands and drives the IALU inputs.
- Sequences multi-cycle RVM (MUL/DIV) operations using the IALU's MUL/DIV command-valid / result-ready pair.
- Captures the IALU result and comparison flag and presents them to writeback with a valid/ready handshake and a destination tag.

---
 rtl/scr1_ialu_issue_pkg.sv | 53 +++++
 rtl/scr1_ialu_issue_if.sv | 24 ++
 rtl/scr1_ialu_issue.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/scr1_ialu_issue_pkg.sv
// Shared types for the IALU issue stage: IALU command encodings, issue FSM states
// and the MUL/DIV command classifier.
package scr1_ialu_issue_pkg;

  localparam int unsigned SCR1_XLEN = 32;

  typedef enum logic [4:0] {
    SCR1_IALU_CMD_NONE   = 5'd0,
    SCR1_IALU_CMD_AND    = 5'd1,
    SCR1_IALU_CMD_OR     = 5'd2,
    SCR1_IALU_CMD_XOR    = 5'd3,
    SCR1_IALU_CMD_ADD    = 5'd4,
    SCR1_IALU_CMD_SUB    = 5'd5,
    SCR1_IALU_CMD_SUB_LT = 5'd6,
    SCR1_IALU_CMD_SUB_LTU= 5'd7,
    SCR1_IALU_CMD_SUB_EQ = 5'd8,
    SCR1_IALU_CMD_SUB_NE = 5'd9,
    SCR1_IALU_CMD_SUB_GE = 5'd10,
    SCR1_IALU_CMD_SUB_GEU= 5'd11,
    SCR1_IALU_CMD_SLL    = 5'd12,
    SCR1_IALU_CMD_SRL    = 5'd13,
    SCR1_IALU_CMD_SRA    = 5'd14,
    SCR1_IALU_CMD_MUL    = 5'd15,
    SCR1_IALU_CMD_MULHU  = 5'd16,
    SCR1_IALU_CMD_MULHSU = 5'd17,
    SCR1_IALU_CMD_MULH   = 5'd18,
    SCR1_IALU_CMD_DIV    = 5'd19,
    SCR1_IALU_CMD_DIVU   = 5'd20,
    SCR1_IALU_CMD_REM    = 5'd21,
    SCR1_IALU_CMD_REMU   = 5'd22
  } type_scr1_ialu_cmd_sel_e;

  localparam int unsigned SCR1_IALU_CMD_WIDTH_E = $bits(type_scr1_ialu_cmd_sel_e);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_RVM = 2'd2,
    WB       = 2'd3
  } type_scr1_ialu_issue_fsm_e;

  // True for commands that run on the multi-cycle MUL/DIV unit
  function automatic logic is_rvm(input logic [SCR1_IALU_CMD_WIDTH_E-1:0] cmd);
    case (cmd)
      SCR1_IALU_CMD_MUL, SCR1_IALU_CMD_MULHU, SCR1_IALU_CMD_MULHSU, SCR1_IALU_CMD_MULH,
      SCR1_IALU_CMD_DIV, SCR1_IALU_CMD_DIVU, SCR1_IALU_CMD_REM, SCR1_IALU_CMD_REMU:
        is_rvm = 1'b1;
      default:
        is_rvm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/scr1_ialu_issue_if.sv
// EXU <-> IALU connection: registered operands/command out, result/compare/MUL-DIV
// ready back. master = issue stage, slave = IALU.
interface scr1_ialu_issue_if #(
  parameter int unsigned XLEN  = scr1_ialu_issue_pkg::SCR1_XLEN,
  parameter int unsigned CMD_W = scr1_ialu_issue_pkg::SCR1_IALU_CMD_WIDTH_E
);
  logic [XLEN-1:0]  exu2ialu_main_op1_o;
  logic [XLEN-1:0]  exu2ialu_main_op2_o;
  logic [CMD_W-1:0] exu2ialu_cmd_o;
  logic             exu2ialu_rvm_cmd_vd_o;
  logic [XLEN-1:0]  ialu2exu_main_res_i;
  logic             ialu2exu_cmp_res_i;
  logic             ialu2exu_rvm_res_rdy_i;

  modport master (
    output exu2ialu_main_op1_o, exu2ialu_main_op2_o, exu2ialu_cmd_o, exu2ialu_rvm_cmd_vd_o,
    input  ialu2exu_main_res_i, ialu2exu_cmp_res_i, ialu2exu_rvm_res_rdy_i
  );

  modport slave (
    input  exu2ialu_main_op1_o, exu2ialu_main_op2_o, exu2ialu_cmd_o, exu2ialu_rvm_cmd_vd_o,
    output ialu2exu_main_res_i, ialu2exu_cmp_res_i, ialu2exu_rvm_res_rdy_i
  );
endinterface

// File: rtl/scr1_ialu_issue.sv
// IALU issue stage: registers decode requests, sequences MUL/DIV, hands results to
// writeback. Optional RVM watchdog enabled by SCR1_IALU_ISSUE_TIMEOUT_EN.
module scr1_ialu_issue
  import scr1_ialu_issue_pkg::*;
#(
  parameter int unsigned XLEN  = SCR1_XLEN,
  parameter int unsigned CMD_W = SCR1_IALU_CMD_WIDTH_E,
  parameter int unsigned TAG_W = 5
`ifdef SCR1_IALU_ISSUE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vd_i,
  output logic              req_rdy_o,
  input  logic [CMD_W-1:0]  req_cmd_i,
  input  logic [XLEN-1:0]   req_op1_i,
  input  logic [XLEN-1:0]   req_op2_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic              flush_i,
  scr1_ialu_issue_if.master ialu,
  output logic              wb_vd_o,
  input  logic              wb_rdy_i,
  output logic [XLEN-1:0]   wb_res_o,
  output logic              wb_cmp_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic              busy_o,
  output logic              err_o
);

  type_scr1_ialu_issue_fsm_e state_q;
  logic [XLEN-1:0]  op1_q;
  logic [XLEN-1:0]  op2_q;
  logic [CMD_W-1:0] cmd_q;
  logic [TAG_W-1:0] tag_q;
  logic             rvm_vd_q;
  logic             wb_vd_q;
  logic [XLEN-1:0]  wb_res_q;
  logic             wb_cmp_q;
  logic [TAG_W-1:0] wb_tag_q;
  logic             req_accept;
  logic             req_is_rvm;

`ifdef SCR1_IALU_ISSUE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  // A request may replace the result leaving WB in the same cycle
  assign req_rdy_o  = !flush_i & ((state_q == IDLE) | ((state_q == WB) & wb_rdy_i));
  assign req_accept = req_vd_i & req_rdy_o;
  assign req_is_rvm = is_rvm(req_cmd_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      cmd_q    <= CMD_W'(SCR1_IALU_CMD_NONE);
      tag_q    <= '0;
      rvm_vd_q <= 1'b0;
      wb_vd_q  <= 1'b0;
      wb_res_q <= '0;
      wb_cmp_q <= 1'b0;
      wb_tag_q <= '0;
`ifdef SCR1_IALU_ISSUE_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else if (flush_i) begin
      // Flush wins over any coincident completion or handshake
      state_q  <= IDLE;
      rvm_vd_q <= 1'b0;
      wb_vd_q  <= 1'b0;
`ifdef SCR1_IALU_ISSUE_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
        end
        EXEC: begin
          wb_res_q <= ialu.ialu2exu_main_res_i;
          wb_cmp_q <= ialu.ialu2exu_cmp_res_i;
          wb_tag_q <= tag_q;
          wb_vd_q  <= 1'b1;
          state_q  <= WB;
        end
        WAIT_RVM: begin
          if (ialu.ialu2exu_rvm_res_rdy_i) begin
            wb_res_q <= ialu.ialu2exu_main_res_i;
            wb_cmp_q <= ialu.ialu2exu_cmp_res_i;
            wb_tag_q <= tag_q;
            rvm_vd_q <= 1'b0;
            wb_vd_q  <= 1'b1;
            state_q  <= WB;
          end
`ifdef SCR1_IALU_ISSUE_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Watchdog: abort the MUL/DIV and retire a zero result
            err_q    <= 1'b1;
            wb_res_q <= '0;
            wb_cmp_q <= 1'b0;
            wb_tag_q <= tag_q;
            rvm_vd_q <= 1'b0;
            wb_vd_q  <= 1'b1;
            state_q  <= WB;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        WB: begin
          if (wb_rdy_i) begin
            wb_vd_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (req_accept) begin
        op1_q    <= req_op1_i;
        op2_q    <= req_op2_i;
        cmd_q    <= req_cmd_i;
        tag_q    <= req_tag_i;
        rvm_vd_q <= req_is_rvm;
        state_q  <= req_is_rvm ? WAIT_RVM : EXEC;
`ifdef SCR1_IALU_ISSUE_TIMEOUT_EN
        cnt_q    <= '0;
`endif
      end
    end
  end

  assign ialu.exu2ialu_main_op1_o   = op1_q;
  assign ialu.exu2ialu_main_op2_o   = op2_q;
  assign ialu.exu2ialu_cmd_o        = cmd_q;
  assign ialu.exu2ialu_rvm_cmd_vd_o = rvm_vd_q;

  assign wb_vd_o  = wb_vd_q;
  assign wb_res_o = wb_res_q;
  assign wb_cmp_o = wb_cmp_q;
  assign wb_tag_o = wb_tag_q;
  assign busy_o   = (state_q != IDLE);

`ifdef SCR1_IALU_ISSUE_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
